// File: rtl/seq_stream_gen.sv
// AXI4-Stream packet source: counter, power-of-BASE, Galois LFSR or constant data with programmable length.
// Optional SEQ_STREAM_GEN_STALL_CNT_EN adds stall_count (cycles with tvalid high and tready low).
module seq_stream_gen #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          PKT_LEN_WIDTH = 8,
  parameter int          BASE          = 3,
  parameter logic [63:0] LFSR_TAPS     = 64'h80200003
) (
  input  logic                      m00_axis_aclk,
  input  logic                      m00_axis_areset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     seed,
  input  logic [PKT_LEN_WIDTH-1:0]  pkt_len,
  input  logic                      m00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  output logic                      busy,
`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
  output logic [15:0]               stall_count,
`endif
  output logic [15:0]               pkt_count
);

  localparam logic [DATA_WIDTH-1:0] P_TAPS = DATA_WIDTH'(LFSR_TAPS);
  localparam logic [DATA_WIDTH-1:0] P_BASE = DATA_WIDTH'(BASE);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [1:0]               r_mode;
  logic [PKT_LEN_WIDTH-1:0] r_last_idx;
  logic [PKT_LEN_WIDTH-1:0] r_beat;
  logic [DATA_WIDTH-1:0]    r_val;
  logic [15:0]              r_pkt_count;
  logic                     w_start;
  logic                     w_hs;
  logic                     w_last;
  logic                     w_done;
  logic                     w_valid;

  function automatic logic [DATA_WIDTH-1:0] first_val(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] s);
    case (m)
      2'd1:    first_val = DATA_WIDTH'(1);
      2'd2:    first_val = (s == '0) ? DATA_WIDTH'(1) : s;
      default: first_val = s;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_val(input logic [1:0] m,
                                                     input logic [DATA_WIDTH-1:0] v);
    case (m)
      2'd0:    next_val = v + DATA_WIDTH'(1);
      2'd1:    next_val = v * P_BASE;
      2'd2:    next_val = (v >> 1) ^ (v[0] ? P_TAPS : '0);
      default: next_val = v;
    endcase
  endfunction

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_hs    = 1'b0;
    w_done  = 1'b0;
    w_last  = (r_beat == r_last_idx);
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_start = 1'b1;
          w_next  = S_STREAM;
        end
      end
      S_STREAM: begin
        w_hs = m00_axis_tready;
        if (w_hs && w_last) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Length is stored as the index of the final beat so a pkt_len of 0 behaves as 1.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_mode      <= 2'd0;
      r_last_idx  <= '0;
      r_beat      <= '0;
      r_val       <= '0;
      r_pkt_count <= 16'd0;
    end else if (w_start) begin
      r_mode      <= mode;
      r_last_idx  <= (pkt_len == '0) ? '0 : pkt_len - PKT_LEN_WIDTH'(1);
      r_beat      <= '0;
      r_val       <= first_val(mode, seed);
    end else if (w_done) begin
      r_beat      <= '0;
      r_val       <= '0;
      r_pkt_count <= r_pkt_count + 16'd1;
    end else if (w_hs) begin
      r_beat      <= r_beat + PKT_LEN_WIDTH'(1);
      r_val       <= next_val(r_mode, r_val);
    end
  end

`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset)                            r_stall_count <= 16'd0;
    else if (w_start)                               r_stall_count <= 16'd0;
    else if (w_valid && !m00_axis_tready &&
             r_stall_count != 16'hFFFF)             r_stall_count <= r_stall_count + 16'd1;
  end

  assign stall_count = r_stall_count;
`endif

  assign w_valid         = (r_state == S_STREAM);
  assign m00_axis_tvalid = w_valid;
  assign m00_axis_tlast  = w_valid & w_last;
  assign m00_axis_tstrb  = {(DATA_WIDTH/8){w_valid}};
  assign m00_axis_tdata  = r_val;
  assign busy            = w_valid;
  assign pkt_count       = r_pkt_count;

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed bench for seq_stream_gen: a 32-bit instance for most cases and an 8-bit instance for power-mode truncation.
module tb_seq_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic [7:0]  pkt_len = 8'd0;
  logic        tready = 1'b1;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast, busy;
  logic [15:0] pkt_count;

  logic        en8 = 1'b0;
  logic [7:0]  tdata8;
  logic [0:0]  tstrb8;
  logic        tvalid8, tlast8, busy8;
  logic [15:0] pkt_count8;
`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] stall_count8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_stream_gen #(.DATA_WIDTH(32), .PKT_LEN_WIDTH(8), .BASE(3)) u_dut (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .enable(enable), .mode(mode),
    .seed(seed), .pkt_len(pkt_len), .m00_axis_tready(tready),
    .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tvalid(tvalid),
    .m00_axis_tlast(tlast), .busy(busy),
`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .pkt_count(pkt_count)
  );

  seq_stream_gen #(.DATA_WIDTH(8), .PKT_LEN_WIDTH(8), .BASE(3)) u_dut8 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .enable(en8), .mode(2'd1),
    .seed(8'd0), .pkt_len(8'd7), .m00_axis_tready(1'b1),
    .m00_axis_tdata(tdata8), .m00_axis_tstrb(tstrb8), .m00_axis_tvalid(tvalid8),
    .m00_axis_tlast(tlast8), .busy(busy8),
`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
    .stall_count(stall_count8),
`endif
    .pkt_count(pkt_count8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Request one packet; returns at the negedge where the first beat is visible.
  task automatic start_pkt(input logic [1:0] m, input logic [31:0] s, input logic [7:0] len);
    @(negedge clk);
    mode = m; seed = s; pkt_len = len; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] exp_d, input logic exp_l);
    check_val({tag, "_vld"},  {31'd0, tvalid}, 32'd1);
    check_val({tag, "_dat"},  tdata, exp_d);
    check_val({tag, "_last"}, {31'd0, tlast}, {31'd0, exp_l});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pw [5];
    logic [7:0]  pw8 [7];
    pw  = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81};
    pw8 = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81, 8'd243, 8'd217};

    #12;
    check_val("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check_val("rst_tdata",  tdata, 32'd0);
    check_val("rst_tstrb",  {28'd0, tstrb}, 32'd0);
    check_val("rst_busy",   {31'd0, busy}, 32'd0);
    check_val("rst_pkts",   {16'd0, pkt_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Power mode, 5 beats.
    start_pkt(2'd1, 32'hDEAD_BEEF, 8'd5);
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("pow%0d", i), pw[i], i == 4);
      check_val($sformatf("pow%0d_strb", i), {28'd0, tstrb}, 32'hF);
      @(negedge clk);
    end
    check_val("pow_after_vld",  {31'd0, tvalid}, 32'd0);
    check_val("pow_after_busy", {31'd0, busy}, 32'd0);
    check_val("pow_after_dat",  tdata, 32'd0);
    check_val("pow_after_strb", {28'd0, tstrb}, 32'd0);
    check_val("pow_pkts",       {16'd0, pkt_count}, 32'd1);

    // Counter wrap with a 3-cycle stall on beat 2.
    start_pkt(2'd0, 32'hFFFF_FFFE, 8'd4);
    check_beat("cnt0", 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    check_beat("cnt1", 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check_beat("cnt2", 32'h0, 1'b0);
    tready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_beat($sformatf("cnt_stall%0d", s), 32'h0, 1'b0);
    end
    tready = 1'b1;
    @(negedge clk);
    check_beat("cnt3", 32'h1, 1'b1);
    @(negedge clk);
    check_val("cnt_pkts", {16'd0, pkt_count}, 32'd2);
`ifdef SEQ_STREAM_GEN_STALL_CNT_EN
    check_val("cnt_stalls", {16'd0, stall_count}, 32'd3);
`endif

    // 8-bit power mode truncation.
    @(negedge clk);
    en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("pw8_%0d_vld", i),  {31'd0, tvalid8}, 32'd1);
      check_val($sformatf("pw8_%0d_dat", i),  {24'd0, tdata8}, {24'd0, pw8[i]});
      check_val($sformatf("pw8_%0d_last", i), {31'd0, tlast8}, (i == 6) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check_val("pw8_after_vld", {31'd0, tvalid8}, 32'd0);
    check_val("pw8_pkts",      {16'd0, pkt_count8}, 32'd1);

    // LFSR with zero seed.
    start_pkt(2'd2, 32'h0, 8'd2);
    check_beat("lfsr0", 32'h0000_0001, 1'b0);
    @(negedge clk);
    check_beat("lfsr1", 32'h8020_0003, 1'b1);
    @(negedge clk);
    check_val("lfsr_pkts", {16'd0, pkt_count}, 32'd3);

    // pkt_len=0 constant, enable held high: back-to-back with one idle cycle.
    @(negedge clk);
    mode = 2'd3; seed = 32'hA5A5_A5A5; pkt_len = 8'd0; enable = 1'b1;
    @(negedge clk);
    check_beat("const_a", 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    check_val("const_gap_vld", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    check_beat("const_b", 32'hA5A5_A5A5, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check_val("const_pkts", {16'd0, pkt_count}, 32'd5);

    // Asynchronous reset mid-packet, then a fresh packet.
    start_pkt(2'd0, 32'd100, 8'd10);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check_beat("pre_rst", 32'd103, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_val("arst_vld",  {31'd0, tvalid}, 32'd0);
    check_val("arst_last", {31'd0, tlast}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_dat",  tdata, 32'd0);
    check_val("arst_pkts", {16'd0, pkt_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_beat($sformatf("fresh%0d", i), 32'd100 + i, i == 9);
      @(negedge clk);
    end
    check_val("fresh_after_vld", {31'd0, tvalid}, 32'd0);
    check_val("fresh_pkts",      {16'd0, pkt_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
